axi4_lite_reg_slave: RTL and testbench
======================================

AXI4_LITE_REG_SLAVE -- requirements
Module: axi4_lite_reg_slave

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 4, data bus width in bytes.
REQ-002 SHALL have parameter ADDR_BYTES, default 4, address bus width in bytes.
REQ-003 SHALL have parameter NUM_REGS, default 16, register count; power of two, at least 2.
REQ-004 SHALL have port aclk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port aresetn  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port awvalid  input  1  write address valid.
REQ-007 SHALL have port awready  output  1  write address ready.
REQ-008 SHALL have port awaddr  input  ADDR_BYTES*8  write byte address.
REQ-009 SHALL have port wvalid  input  1  write data valid.
REQ-010 SHALL have port wready  output  1  write data ready.
REQ-011 SHALL have port wdata  input  DATA_BYTES*8  write data.
REQ-012 SHALL have port wstrb  input  DATA_BYTES  byte enables.
REQ-013 SHALL have port bvalid  output  1  write response valid.
REQ-014 SHALL have port bready  input  1  write response ready.
REQ-015 SHALL have port bresp  output  2  write response code.
REQ-016 SHALL have port arvalid  input  1  read address valid.
REQ-017 SHALL have port arready  output  1  read address ready.
REQ-018 SHALL have port araddr  input  ADDR_BYTES*8  read byte address.
REQ-019 SHALL have port rvalid  output  1  read data valid.
REQ-020 SHALL have port rready  input  1  read data ready.
REQ-021 SHALL have port rdata  output  DATA_BYTES*8  read data.
REQ-022 SHALL have port rresp  output  2  read response code.
REQ-023 SHALL have port reg_q  output  NUM_REGS*DATA_BYTES*8  all registers; register i at slice i.
REQ-024 SHALL have port reg_wstb  output  NUM_REGS  one-cycle pulse per register written.

Function
REQ-025 SHALL decode index as addr[log2(DATA_BYTES) +: log2(NUM_REGS)]; ignore the low log2(DATA_BYTES) bits; any set bit above the index field makes the access out-of-range.
REQ-026 SHALL capture AW and W independently; awready=1 only in WR_IDLE with no AW held; wready=1 only in WR_IDLE with no W held.
REQ-027 SHALL move the write FSM WR_IDLE->WR_RESP on the edge where both AW and W are held, including the same-cycle case. It SHALL update the register on that edge, byte-wise per wstrb, and pulse its reg_wstb bit for that one cycle.
REQ-028 SHALL hold bvalid=1 in WR_RESP until bready; it SHALL return to WR_IDLE and clear both held flags on that handshake; bvalid SHALL NOT drop without bready.
REQ-029 SHALL keep arready=1 in RD_IDLE. An arvalid handshake SHALL register rdata/rresp and enter RD_DATA, so rvalid rises one cycle after the handshake.
REQ-030 SHALL hold rvalid, rdata and rresp stable in RD_DATA with arready=0 until rready, then return to RD_IDLE.
REQ-031 SHALL run the read and write channels concurrently. A read and a write to the same register on the same edge SHALL return the pre-write value.
REQ-032 SHALL leave registers unchanged on an out-of-range write, with no reg_wstb pulse; an out-of-range read SHALL return rdata=0.
REQ-033 SHALL issue in-range responses as OKAY (2'b00); wstrb=0 SHALL give OKAY with no change and no reg_wstb pulse.

Reset
REQ-034 SHALL, while aresetn=0 and independent of aclk, force the following: registers=0, reg_wstb=0, bvalid=0, rvalid=0, rdata=0, bresp=rresp=OKAY, awready=wready=arready=0, held flags cleared, FSMs in WR_IDLE/RD_IDLE.
REQ-035 SHALL abandon any pending write or read when reset asserts mid-transaction; the ready outputs SHALL go to 1 on the first edge after deassertion.

Configuration
REQ-036 SHALL, with AXI4_LITE_REG_SLAVE_SLVERR_EN defined, respond SLVERR (2'b10) to out-of-range accesses; without it, out-of-range accesses SHALL respond OKAY. Data effects per REQ-032 apply in both cases.

Structure
REQ-037 SHALL take from shared package axi4_lite_pkg: resp_t (OKAY, EXOKAY, SLVERR, DECERR), wr_state_t (WR_IDLE, WR_RESP) and rd_state_t (RD_IDLE, RD_DATA).
REQ-038 SHALL place the write-channel capture/FSM in sub-module axi4_lite_wr_ctrl; decode and register storage stay in the top module.

Verification
REQ-039 SHALL test: AW then W two cycles later, addr 0x08, wdata 0xDEADBEEF, wstrb 0xF -> reg2=0xDEADBEEF, reg_wstb[2] pulses once, bresp OKAY.
REQ-040 SHALL test: same-cycle AW+W addr 0x04, wstrb 0x2, wdata 0x0000AB00, reg1 previously 0x11223344 -> reg1=0x1122AB44.
REQ-041 SHALL test: read 0x08 with rready low 3 cycles -> rvalid held, rdata 0xDEADBEEF stable, arready=0 until handshake.
REQ-042 SHALL test: write/read addr 0x100 (NUM_REGS=16) -> no register change, rdata 0, resp SLVERR with macro and OKAY without.
REQ-043 SHALL test: same-edge read and write of reg3 (old 0x5, new 0x9) -> rdata 0x5, reg3 then 0x9.
REQ-044 SHALL test: reset asserted with bvalid=1 pending -> bvalid=0 immediately, all registers 0, and a new write succeeds after release.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes and the write/read channel state encodings.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi4_lite_wr_ctrl.sv
// AXI4-Lite write channel: independent AW/W capture, commit strobe and B response FSM.
module axi4_lite_wr_ctrl
  import axi4_lite_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = 4
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          awvalid,
  output logic          awready,
  input  logic [AW-1:0] awaddr,
  input  logic          wvalid,
  output logic          wready,
  input  logic [DW-1:0] wdata,
  input  logic [SW-1:0] wstrb,
  output logic          bvalid,
  input  logic          bready,
  output resp_t         bresp,
  input  resp_t         wr_resp,
  output logic          commit,
  output logic [AW-1:0] commit_addr,
  output logic [DW-1:0] commit_data,
  output logic [SW-1:0] commit_strb
);

  wr_state_t     state;
  logic          aw_held, w_held;
  logic          aw_take, w_take, aw_have, w_have;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic [SW-1:0] strb_q;

  // Commit is visible on the same edge as the last handshake, so a same-cycle
  // AW+W pair writes without first parking in the holding registers.
  always_comb begin
    aw_take     = awvalid && awready;
    w_take      = wvalid && wready;
    aw_have     = aw_held || aw_take;
    w_have      = w_held || w_take;
    commit      = (state == WR_IDLE) && aw_have && w_have;
    commit_addr = aw_held ? addr_q : awaddr;
    commit_data = w_held ? data_q : wdata;
    commit_strb = w_held ? strb_q : wstrb;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // below sees the pre-edge values of state, flags and ready outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= WR_IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
    end else begin
      case (state)
        WR_IDLE: begin
          if (aw_take) addr_q <= awaddr;
          if (w_take) begin
            data_q <= wdata;
            strb_q <= wstrb;
          end
          aw_held <= aw_have;
          w_held  <= w_have;
          if (commit) begin
            state   <= WR_RESP;
            bvalid  <= 1'b1;
            bresp   <= wr_resp;
            awready <= 1'b0;
            wready  <= 1'b0;
          end else begin
            awready <= !aw_have;
            wready  <= !w_have;
          end
        end
        WR_RESP: begin
          if (bready) begin
            state   <= WR_IDLE;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
        default: state <= WR_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register file slave with address decode, byte-strobed storage and read channel.
// Define AXI4_LITE_REG_SLAVE_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axi4_lite_reg_slave
  import axi4_lite_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_BYTES = 4,
  parameter int NUM_REGS   = 16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            awvalid,
  output logic                            awready,
  input  logic [ADDR_BYTES*8-1:0]         awaddr,
  input  logic                            wvalid,
  output logic                            wready,
  input  logic [DATA_BYTES*8-1:0]         wdata,
  input  logic [DATA_BYTES-1:0]           wstrb,
  output logic                            bvalid,
  input  logic                            bready,
  output resp_t                           bresp,
  input  logic                            arvalid,
  output logic                            arready,
  input  logic [ADDR_BYTES*8-1:0]         araddr,
  output logic                            rvalid,
  input  logic                            rready,
  output logic [DATA_BYTES*8-1:0]         rdata,
  output resp_t                           rresp,
  output logic [NUM_REGS*DATA_BYTES*8-1:0] reg_q,
  output logic [NUM_REGS-1:0]             reg_wstb
);

  localparam int DW      = DATA_BYTES * 8;
  localparam int AW      = ADDR_BYTES * 8;
  localparam int IDX_LSB = $clog2(DATA_BYTES);
  localparam int IDX_W   = $clog2(NUM_REGS);
  localparam int HI_LSB  = IDX_LSB + IDX_W;

  logic [DW-1:0]         regs [NUM_REGS];
  logic                  wr_commit, wr_oor, rd_oor;
  logic [AW-1:0]         wr_addr;
  logic [DW-1:0]         wr_data;
  logic [DATA_BYTES-1:0] wr_strb;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  resp_t                 wr_resp, rd_resp;
  rd_state_t             rd_state;

  axi4_lite_wr_ctrl #(.AW(AW), .DW(DW), .SW(DATA_BYTES)) u_wr_ctrl (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .awvalid     (awvalid),
    .awready     (awready),
    .awaddr      (awaddr),
    .wvalid      (wvalid),
    .wready      (wready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .bvalid      (bvalid),
    .bready      (bready),
    .bresp       (bresp),
    .wr_resp     (wr_resp),
    .commit      (wr_commit),
    .commit_addr (wr_addr),
    .commit_data (wr_data),
    .commit_strb (wr_strb)
  );

  // Any address bit above the index field puts the access out of range.
  always_comb begin
    wr_idx  = wr_addr[IDX_LSB +: IDX_W];
    rd_idx  = araddr[IDX_LSB +: IDX_W];
    wr_oor  = |(wr_addr >> HI_LSB);
    rd_oor  = |(araddr >> HI_LSB);
    wr_resp = OKAY;
    rd_resp = OKAY;
`ifdef AXI4_LITE_REG_SLAVE_SLVERR_EN
    if (wr_oor) wr_resp = SLVERR;
    if (rd_oor) rd_resp = SLVERR;
`endif
  end

  // NOTE: the register array is reset explicitly because reg_q must read zero
  // during reset; this forces flops rather than a RAM macro, which is intended.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wstb <= '0;
    end else begin
      reg_wstb <= '0;
      if (wr_commit && !wr_oor && (|wr_strb)) begin
        reg_wstb[wr_idx] <= 1'b1;
        for (int b = 0; b < DATA_BYTES; b++)
          if (wr_strb[b]) regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DW +: DW] = regs[g];
  end

  // Read data is sampled from the pre-edge register value, so a same-edge
  // write to the same register is not visible to this read.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state <= RD_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (arvalid && arready) begin
            rd_state <= RD_DATA;
            arready  <= 1'b0;
            rvalid   <= 1'b1;
            rdata    <= rd_oor ? '0 : regs[rd_idx];
            rresp    <= rd_resp;
          end else begin
            arready <= 1'b1;
          end
        end
        RD_DATA: begin
          if (rready) begin
            rd_state <= RD_IDLE;
            rvalid   <= 1'b0;
            arready  <= 1'b1;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Randomized and directed bench for axi4_lite_reg_slave against an array-based register model.
module tb_axi4_lite_reg_slave;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   awaddr, araddr, wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [511:0]  reg_q;
  logic [15:0]   reg_wstb;

  logic [31:0]   model [16];
  int            total = 0;
  int            bad = 0;

  axi4_lite_reg_slave dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .awvalid  (awvalid),
    .awready  (awready),
    .awaddr   (awaddr),
    .wvalid   (wvalid),
    .wready   (wready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .bvalid   (bvalid),
    .bready   (bready),
    .bresp    (bresp),
    .arvalid  (arvalid),
    .arready  (arready),
    .araddr   (araddr),
    .rvalid   (rvalid),
    .rready   (rready),
    .rdata    (rdata),
    .rresp    (rresp),
    .reg_q    (reg_q),
    .reg_wstb (reg_wstb)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit is_oor(input logic [31:0] a);
    return a >= 32'd64;
  endfunction

  function automatic logic [1:0] exp_resp(input bit oor);
`ifdef AXI4_LITE_REG_SLAVE_SLVERR_EN
    return oor ? 2'b10 : 2'b00;
`else
    return 2'b00;
`endif
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_reg%0d", tag, i), reg_q[i*32 +: 32], model[i]);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int awd, input int wd, input int bd);
    bit aw_done, w_done, aw_fire, w_fire;
    int cyc, idx;
    logic [15:0] exp_stb;
    awaddr = addr; wdata = data; wstrb = strb;
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 64) begin
      awvalid = !aw_done && cyc >= awd;
      wvalid  = !w_done && cyc >= wd;
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge aclk); #1;
      aw_done |= aw_fire;
      w_done  |= w_fire;
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    check("wr_handshake", {aw_done, w_done}, 2'b11);
    idx = (addr / 4) % 16;
    exp_stb = '0;
    if (!is_oor(addr) && strb != 0) begin
      exp_stb[idx] = 1'b1;
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
    end
    check("reg_wstb", reg_wstb, exp_stb);
    check("bvalid_up", bvalid, 1'b1);
    check("bresp", bresp, exp_resp(is_oor(addr)));
    for (int i = 0; i < bd; i++) begin
      @(posedge aclk); #1;
      check("bvalid_hold", bvalid, 1'b1);
      check("reg_wstb_once", reg_wstb, 16'h0);
    end
    bready = 1;
    @(posedge aclk); #1;
    bready = 0;
    check("bvalid_down", bvalid, 1'b0);
    check_regs("wr");
  endtask

  task automatic do_read(input logic [31:0] addr, input int rd);
    int cyc;
    logic [31:0] exp;
    araddr = addr; arvalid = 1; cyc = 0;
    while (!arready && cyc < 16) begin
      @(posedge aclk); #1;
      cyc++;
    end
    check("arready_idle", arready, 1'b1);
    @(posedge aclk); #1;
    arvalid = 0;
    exp = is_oor(addr) ? 32'h0 : model[(addr / 4) % 16];
    check("rvalid_up", rvalid, 1'b1);
    check("rdata", rdata, exp);
    check("rresp", rresp, exp_resp(is_oor(addr)));
    check("arready_busy", arready, 1'b0);
    for (int i = 0; i < rd; i++) begin
      @(posedge aclk); #1;
      check("rvalid_hold", rvalid, 1'b1);
      check("rdata_hold", rdata, exp);
      check("arready_hold", arready, 1'b0);
    end
    rready = 1;
    @(posedge aclk); #1;
    rready = 0;
    check("rvalid_down", rvalid, 1'b0);
    check("arready_back", arready, 1'b1);
  endtask

  initial begin
    logic [31:0] a;
    aresetn = 0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    #1;
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_resp", {bresp, rresp}, 4'h0);
    check("rst_wstb", reg_wstb, 16'h0);
    check_regs("rst");
    #12 aresetn = 1;
    @(posedge aclk); #1;
    check("rel_ready", {awready, wready, arready}, 3'b111);

    // AW first, W two cycles later.
    do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 2, 1);
    // Read back with rready held low for three cycles.
    do_read(32'h08, 3);
    // Same-cycle AW+W partial strobe.
    do_write(32'h04, 32'h11223344, 4'hF, 0, 0, 0);
    do_write(32'h04, 32'h0000AB00, 4'h2, 0, 0, 0);
    check("reg1_merge", reg_q[63:32], 32'h1122AB44);
    // Out-of-range write and read, then a zero-strobe write.
    do_write(32'h100, 32'hFFFFFFFF, 4'hF, 1, 0, 0);
    do_read(32'h100, 0);
    do_write(32'h0C, 32'hFFFFFFFF, 4'h0, 0, 0, 0);

    // Same-edge read and write of reg3 returns the old value.
    do_write(32'h0C, 32'h5, 4'hF, 0, 0, 0);
    awaddr = 32'h0C; wdata = 32'h9; wstrb = 4'hF; araddr = 32'h0C;
    check("same_edge_ready", {awready, wready, arready}, 3'b111);
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    model[3] = 32'h9;
    check("same_edge_rvalid", rvalid, 1'b1);
    check("same_edge_rdata", rdata, 32'h5);
    check("same_edge_reg3", reg_q[127:96], 32'h9);
    bready = 1; rready = 1;
    @(posedge aclk); #1;
    bready = 0; rready = 0;

    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 4) == 0) ? ($urandom | 32'h100) : $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2));
      else
        do_read(a, $urandom_range(0, 3));
    end

    // Reset with a write response pending.
    awaddr = 32'h10; wdata = 32'hCAFE0001; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0;
    check("pend_bvalid", bvalid, 1'b1);
    #2 aresetn = 0;
    #1;
    for (int i = 0; i < 16; i++) model[i] = '0;
    check("midrst_bvalid", bvalid, 1'b0);
    check("midrst_ready", {awready, wready, arready}, 3'b000);
    check_regs("midrst");
    @(posedge aclk); #3 aresetn = 1;
    @(posedge aclk); #1;
    check("rerel_ready", {awready, wready, arready}, 3'b111);
    do_write(32'h14, 32'h600DF00D, 4'hF, 0, 1, 0);
    do_read(32'h14, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
